// File: rtl/dmem_responder.sv
// Multi-cycle data memory with valid/ready request and response channels.
// One request is in flight at a time, with a fixed number of wait states before the response.
module dmem_responder #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ReqWrite,
  input  logic [ADDR_W-1:0] ReqAddr,
  input  logic [DATA_W-1:0] ReqWData,
  output logic              RespValid,
  input  logic              RespReady,
  output logic [DATA_W-1:0] RespRData,
  output logic              RespWasWrite,
  output logic              Busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state;
  logic [3:0]        count;
  logic              cap_write;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;
  logic              enter_resp;
  logic [DATA_W-1:0] mem [2**ADDR_W];

  assign ReqReady   = (state == S_IDLE);
  assign Busy       = (state != S_IDLE);
  assign enter_resp = (state == S_WAIT) && (count == 4'd0);

  // Memory is never reset; a write commits on the same edge that raises its response.
  always_ff @(posedge Clk) begin
    if (enter_resp && cap_write) begin
      mem[cap_addr] <= cap_wdata;
    end
  end

  // Every request passes through S_WAIT, so RESP is entered WAIT_CYCLES+1 edges after acceptance.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state        <= S_IDLE;
      count        <= 4'd0;
      cap_write    <= 1'b0;
      cap_addr     <= '0;
      cap_wdata    <= '0;
      RespValid    <= 1'b0;
      RespRData    <= '0;
      RespWasWrite <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ReqValid) begin
            cap_write <= ReqWrite;
            cap_addr  <= ReqAddr;
            cap_wdata <= ReqWData;
            count     <= 4'(WAIT_CYCLES);
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (count == 4'd0) begin
            state        <= S_RESP;
            RespValid    <= 1'b1;
            RespWasWrite <= cap_write;
            RespRData    <= cap_write ? cap_wdata : mem[cap_addr];
          end else begin
            count <= count - 4'd1;
          end
        end
        S_RESP: begin
          if (RespReady) begin
            RespValid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;

  logic        req_valid, req_write, resp_ready;
  logic [6:0]  req_addr;
  logic [31:0] req_wdata;
  logic        req_ready, resp_valid, resp_was_write, busy;
  logic [31:0] resp_rdata;

  logic        req_valid_z, req_write_z, resp_ready_z;
  logic [6:0]  req_addr_z;
  logic [31:0] req_wdata_z;
  logic        req_ready_z, resp_valid_z, resp_was_write_z, busy_z;
  logic [31:0] resp_rdata_z;

  int checks = 0;
  int errors = 0;

  dmem_responder #(.ADDR_W(7), .DATA_W(32), .WAIT_CYCLES(2)) dut (
    .Clk(clk), .Rst_n(rst_n),
    .ReqValid(req_valid), .ReqReady(req_ready), .ReqWrite(req_write),
    .ReqAddr(req_addr), .ReqWData(req_wdata),
    .RespValid(resp_valid), .RespReady(resp_ready), .RespRData(resp_rdata),
    .RespWasWrite(resp_was_write), .Busy(busy)
  );

  dmem_responder #(.ADDR_W(7), .DATA_W(32), .WAIT_CYCLES(0)) dut_z (
    .Clk(clk), .Rst_n(rst_n),
    .ReqValid(req_valid_z), .ReqReady(req_ready_z), .ReqWrite(req_write_z),
    .ReqAddr(req_addr_z), .ReqWData(req_wdata_z),
    .RespValid(resp_valid_z), .RespReady(resp_ready_z), .RespRData(resp_rdata_z),
    .RespWasWrite(resp_was_write_z), .Busy(busy_z)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full transaction on the two-wait-state instance with RespReady held high.
  task automatic applyStimulus(input logic wr, input logic [6:0] a, input logic [31:0] d,
                               input logic [31:0] exp_data, input string tag);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    step();
    checkOutput({tag, ".busy"}, {31'd0, busy}, 32'd1);
    req_valid = 1'b0;
    step();
    step();
    checkOutput({tag, ".early"}, {31'd0, resp_valid}, 32'd0);
    step();
    checkOutput({tag, ".valid"}, {31'd0, resp_valid}, 32'd1);
    checkOutput({tag, ".was_write"}, {31'd0, resp_was_write}, {31'd0, wr});
    checkOutput({tag, ".rdata"}, resp_rdata, exp_data);
    step();
    checkOutput({tag, ".ready_after"}, {31'd0, req_ready}, 32'd1);
  endtask

  task automatic applyStimulusZero(input logic wr, input logic [6:0] a, input logic [31:0] d,
                                   input logic [31:0] exp_data, input string tag);
    req_valid_z = 1'b1; req_write_z = wr; req_addr_z = a; req_wdata_z = d;
    step();
    checkOutput({tag, ".early"}, {31'd0, resp_valid_z}, 32'd0);
    req_valid_z = 1'b0;
    step();
    checkOutput({tag, ".valid"}, {31'd0, resp_valid_z}, 32'd1);
    checkOutput({tag, ".was_write"}, {31'd0, resp_was_write_z}, {31'd0, wr});
    checkOutput({tag, ".rdata"}, resp_rdata_z, exp_data);
    step();
    checkOutput({tag, ".ready_after"}, {31'd0, req_ready_z}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
    req_valid_z = 1'b0; req_write_z = 1'b0; req_addr_z = '0; req_wdata_z = '0; resp_ready_z = 1'b1;

    repeat (3) step();
    checkOutput("rst.in_reset_valid", {31'd0, resp_valid}, 32'd0);
    rst_n = 1'b1;
    step();
    checkOutput("rst.req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("rst.busy", {31'd0, busy}, 32'd0);
    checkOutput("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("rst.resp_rdata", resp_rdata, 32'd0);
    checkOutput("rst.was_write", {31'd0, resp_was_write}, 32'd0);
    checkOutput("rst.z_req_ready", {31'd0, req_ready_z}, 32'd1);

    applyStimulus(1'b1, 7'd5, 32'hDEADBEEF, 32'hDEADBEEF, "wr5");
    applyStimulus(1'b0, 7'd5, 32'h0, 32'hDEADBEEF, "rd5");

    // Back-pressure: response must hold while a stray request is ignored.
    resp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 7'd5;
    step();
    req_valid = 1'b0;
    step(); step(); step();
    checkOutput("bp.valid", {31'd0, resp_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      req_valid = (i == 0); req_write = 1'b1; req_addr = 7'd5; req_wdata = 32'h0BAD0BAD;
      step();
      checkOutput("bp.hold_valid", {31'd0, resp_valid}, 32'd1);
      checkOutput("bp.hold_rdata", resp_rdata, 32'hDEADBEEF);
      checkOutput("bp.req_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    step();
    checkOutput("bp.release_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("bp.release_ready", {31'd0, req_ready}, 32'd1);
    applyStimulus(1'b0, 7'd5, 32'h0, 32'hDEADBEEF, "rd5.after_bp");

    // Reset while a write is waiting abandons it.
    applyStimulus(1'b1, 7'd9, 32'h00000011, 32'h00000011, "wr9");
    req_valid = 1'b1; req_write = 1'b1; req_addr = 7'd9; req_wdata = 32'hFFFFFFFF;
    step();
    req_valid = 1'b0;
    step();
    checkOutput("midwr.busy", {31'd0, busy}, 32'd1);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("midwr.busy_async", {31'd0, busy}, 32'd0);
    checkOutput("midwr.ready_async", {31'd0, req_ready}, 32'd1);
    checkOutput("midwr.valid_async", {31'd0, resp_valid}, 32'd0);
    #1 rst_n = 1'b1;
    step();
    applyStimulus(1'b0, 7'd9, 32'h0, 32'h00000011, "rd9.after_rst");

    // Reset while a response is pending drops RespValid without a clock.
    resp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 7'd5;
    step();
    req_valid = 1'b0;
    step(); step(); step();
    checkOutput("rstresp.valid", {31'd0, resp_valid}, 32'd1);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("rstresp.valid_async", {31'd0, resp_valid}, 32'd0);
    checkOutput("rstresp.rdata_async", resp_rdata, 32'd0);
    #1 rst_n = 1'b1;
    resp_ready = 1'b1;
    step();
    checkOutput("rstresp.ready", {31'd0, req_ready}, 32'd1);

    // Request inputs changing after acceptance must not disturb the captured write.
    applyStimulus(1'b1, 7'd21, 32'h00002121, 32'h00002121, "wr21");
    req_valid = 1'b1; req_write = 1'b1; req_addr = 7'd20; req_wdata = 32'hCAFEF00D;
    step();
    req_valid = 1'b0; req_addr = 7'd21; req_wdata = 32'h0;
    step(); step(); step();
    checkOutput("chg.valid", {31'd0, resp_valid}, 32'd1);
    checkOutput("chg.echo", resp_rdata, 32'hCAFEF00D);
    step();
    applyStimulus(1'b0, 7'd20, 32'h0, 32'hCAFEF00D, "chg.rd20");
    applyStimulus(1'b0, 7'd21, 32'h0, 32'h00002121, "chg.rd21");

    // Zero-wait instance, including the top address and a wrap check on address 0.
    applyStimulusZero(1'b1, 7'd0, 32'hA5A5A5A5, 32'hA5A5A5A5, "z.wr0");
    applyStimulusZero(1'b1, 7'd127, 32'h12345678, 32'h12345678, "z.wr127");
    applyStimulusZero(1'b0, 7'd127, 32'h0, 32'h12345678, "z.rd127");
    applyStimulusZero(1'b0, 7'd0, 32'h0, 32'hA5A5A5A5, "z.rd0");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
